// File: rtl/balance_seq_if.sv
// Signal bundle between balance_seq, the inertial front end, the balance datapath
// and the motor-command consumer.
interface balance_seq_if;
    logic               vld;
    logic               pwr_up_req;
    logic               too_fast;
    logic signed [11:0] lft_spd_in;
    logic signed [11:0] rght_spd_in;
    logic               dp_vld;
    logic               dp_pwr_up;
    logic signed [11:0] lft_spd;
    logic signed [11:0] rght_spd;
    logic               spd_vld;
    logic               fault;
    logic               busy;

    modport master (
        output vld, pwr_up_req, too_fast, lft_spd_in, rght_spd_in,
        input  dp_vld, dp_pwr_up, lft_spd, rght_spd, spd_vld, fault, busy
    );

    modport slave (
        input  vld, pwr_up_req, too_fast, lft_spd_in, rght_spd_in,
        output dp_vld, dp_pwr_up, lft_spd, rght_spd, spd_vld, fault, busy
    );
endinterface

// File: rtl/balance_seq.sv
// Balance sequencer: gates samples into the fixed-latency datapath by power state,
// tracks them in flight, captures wheel speeds and latches the over-speed fault.
module balance_seq #(
    parameter int LAT       = 3,
    parameter int FAULT_CNT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    balance_seq_if.slave bus
);

    typedef enum logic [1:0] {OFF, RUN, DRAIN, FAULT} state_t;

    localparam logic [3:0] TRIP_AT = 4'(FAULT_CNT - 1);

    state_t             state, next_state;
    logic [LAT-1:0]     trk;
    logic [3:0]         cnt;
    logic signed [11:0] lft_q, rght_q;
    logic               spd_vld_q;
    logic               cap, trip, clr_spd;

    assign bus.dp_vld    = (state == RUN) && bus.vld;
    assign bus.dp_pwr_up = (state != OFF);
    assign bus.fault     = (state == FAULT);
    assign bus.busy      = |trk;
    assign bus.lft_spd   = lft_q;
    assign bus.rght_spd  = rght_q;
    assign bus.spd_vld   = spd_vld_q;

    // NOTE: every output of this block gets a default first so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        clr_spd    = 1'b0;
        cap        = trk[LAT-1] && (state == RUN || state == DRAIN);
        trip       = cap && bus.too_fast && (cnt >= TRIP_AT);
        case (state)
            OFF: begin
                if (bus.pwr_up_req) next_state = RUN;
            end
            RUN: begin
                if (trip) begin
                    next_state = FAULT;
                    clr_spd    = 1'b1;
                end else if (!bus.pwr_up_req) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (trip) begin
                    next_state = FAULT;
                    clr_spd    = 1'b1;
                end else if (bus.pwr_up_req) begin
                    next_state = RUN;
                end else if (trk == '0) begin
                    next_state = OFF;
                    clr_spd    = 1'b1;
                end
            end
            FAULT: begin
                if (!bus.pwr_up_req) next_state = OFF;
            end
            default: next_state = OFF;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the values from before the edge regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= OFF;
        else        state <= next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk       <= '0;
            cnt       <= '0;
            lft_q     <= '0;
            rght_q    <= '0;
            spd_vld_q <= 1'b0;
        end else begin
            // A fault discards every tag still travelling through the datapath.
            if (trip || state == FAULT) trk <= '0;
            else                        trk <= (trk << 1) | LAT'(bus.dp_vld);

            if (state == OFF) begin
                cnt <= '0;
            end else if (cap) begin
                if (bus.too_fast) cnt <= (cnt == 4'hF) ? cnt : cnt + 4'd1;
                else              cnt <= '0;
            end

            // A tripping capture lands here via clr_spd, so its speeds are never taken.
            if (clr_spd) begin
                lft_q  <= '0;
                rght_q <= '0;
            end else if (cap) begin
                lft_q  <= bus.lft_spd_in;
                rght_q <= bus.rght_spd_in;
            end

            spd_vld_q <= cap && !trip;
        end
    end

endmodule
